// File: rtl/mrhy4_serial_to_parallel.sv
// Digit-serial redundant radix-4 (n2/p/pp, LSD first) to signed parallel word converter.
// Latency: the word is presented on out_valid 1 cycle after the last digit of its frame is accepted.
// Backpressure: one-entry output register; a frame completing while the register is full and not being drained is dropped (overrun pulse).
module mrhy4_serial_to_parallel #(
  parameter int NDIG = 8,
  parameter int OW   = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_en,
  input  logic          in_sof,
  input  logic          in_n2,
  input  logic          in_p,
  input  logic          in_pp,
  output logic [OW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          overrun,
  output logic          frame_abort
);

  localparam int KW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_COLLECT = 1'b1;

  logic [0:0]           state;
  logic [KW-1:0]        k;
  logic signed [OW-1:0] acc;

  logic signed [OW-1:0] digit;
  logic signed [OW-1:0] digit_sh;
  logic signed [OW-1:0] acc_sum;
  logic [KW:0]          sh_amt;
  logic                 accept_last;
  logic                 restart_in_frame;

  // Digit value, weighted by 4^k, folded into the running sum.
  always_comb begin
    digit    = {{(OW-1){1'b0}}, in_p} + {{(OW-1){1'b0}}, in_pp}
             - {{(OW-2){1'b0}}, in_n2, 1'b0};
    sh_amt   = {k, 1'b0};
    digit_sh = digit <<< sh_amt;
    acc_sum  = acc + digit_sh;
  end

  // The final digit of a frame completes the word; a SOF inside a frame restarts it.
  assign accept_last      = in_en && !in_sof && (state == S_COLLECT) && (k == K_LAST);
  assign restart_in_frame = in_en && in_sof && (state == S_COLLECT);

  // Frame alignment FSM and accumulator; gaps (in_en=0) simply hold everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      k     <= '0;
      acc   <= '0;
    end else if (in_en) begin
      if (in_sof) begin
        acc   <= digit;
        k     <= KW'(1);
        state <= S_COLLECT;
      end else if (state == S_COLLECT) begin
        acc <= acc_sum;
        if (k == K_LAST) begin
          k     <= '0;
          state <= S_IDLE;
        end else begin
          k <= k + KW'(1);
        end
      end
    end
  end

  // Output register with valid/ready; a full, stalled register drops the new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      overrun     <= 1'b0;
      frame_abort <= restart_in_frame;
      if (accept_last) begin
        if (!out_valid || out_ready) begin
          out_data  <= acc_sum;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mrhy4_serial_to_parallel.sv
// Directed bench for the serial-to-parallel converter.
// Inputs change just after the falling edge; outputs are observed there too.
// Pulse/valid counts are gathered on the rising edge by a small monitor.
module tb_mrhy4_serial_to_parallel;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_en, in_sof, in_n2, in_p, in_pp;
  logic [17:0] out_data;
  logic        out_valid, out_ready, overrun, frame_abort;

  int n_vec = 0;
  int n_err = 0;

  int abort_cnt   = 0;
  int overrun_cnt = 0;
  int valid_cnt   = 0;

  always #5 clk = ~clk;

  mrhy4_serial_to_parallel #(.NDIG(8), .OW(18)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_en      (in_en),
    .in_sof     (in_sof),
    .in_n2      (in_n2),
    .in_p       (in_p),
    .in_pp      (in_pp),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun),
    .frame_abort(frame_abort)
  );

  // Count cycles where each flag was high (values as they stood before this edge).
  always @(posedge clk) begin
    if (frame_abort === 1'b1) abort_cnt   <= abort_cnt + 1;
    if (overrun === 1'b1)     overrun_cnt <= overrun_cnt + 1;
    if (out_valid === 1'b1)   valid_cnt   <= valid_cnt + 1;
  end

  // Codes are {n2,p,pp}; digit i sits in codes[3i+2:3i].
  task automatic send_digits(input logic [23:0] codes, input int nd, input int gap);
    for (int i = 0; i < nd; i++) begin
      if (i > 0) begin
        repeat (gap) begin
          @(negedge clk);
          in_en  = 1'b0;
          in_sof = 1'b0;
        end
      end
      @(negedge clk);
      in_en  = 1'b1;
      in_sof = (i == 0);
      {in_n2, in_p, in_pp} = codes[3*i +: 3];
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_en  = 1'b0;
    in_sof = 1'b0;
    {in_n2, in_p, in_pp} = 3'b000;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0;
    in_en = 1'b0; in_sof = 1'b0; {in_n2, in_p, in_pp} = 3'b000;
    repeat (3) @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_vec++; if (out_data !== 18'd0) begin n_err++; $display("FAIL reset_data: got %h want 0", out_data); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_vec++; if (frame_abort !== 1'b0) begin n_err++; $display("FAIL reset_abort: got %b want 0", frame_abort); end
    rst = 1'b0;
    idle_cycle();
  endtask

  task automatic test_all_ones();
    out_ready = 1'b0;
    send_digits({8{3'b010}}, 8, 0);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ones_early_valid: got %b want 0", out_valid); end
    idle_cycle();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ones_valid: got %b want 1", out_valid); end
    n_vec++; if (out_data !== 18'd21845) begin n_err++; $display("FAIL ones_data: got %0d want 21845", $signed(out_data)); end
    out_ready = 1'b1;
    idle_cycle();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ones_consume: got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_extremes();
    out_ready = 1'b1;
    send_digits({8{3'b100}}, 8, 0);
    idle_cycle();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL neg_valid: got %b want 1", out_valid); end
    n_vec++; if (out_data !== 18'h35556) begin n_err++; $display("FAIL neg_data: got %0d want -43690", $signed(out_data)); end
    idle_cycle();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL neg_drop: got %b want 0", out_valid); end
    send_digits({8{3'b011}}, 8, 0);
    idle_cycle();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL pos_valid: got %b want 1", out_valid); end
    n_vec++; if (out_data !== 18'd43690) begin n_err++; $display("FAIL pos_data: got %0d want 43690", $signed(out_data)); end
    idle_cycle();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL pos_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_gaps();
    out_ready = 1'b1;
    // d0=+2, d1=-1, d2=0 via {1,1,1}, rest 0 -> -2
    send_digits({3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b111, 3'b110, 3'b011}, 8, 3);
    idle_cycle();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL gap_valid: got %b want 1", out_valid); end
    n_vec++; if (out_data !== 18'h3FFFE) begin n_err++; $display("FAIL gap_data: got %0d want -2", $signed(out_data)); end
    idle_cycle();
  endtask

  task automatic test_backpressure();
    // Stalled consumer: second word is dropped
    out_ready = 1'b0;
    send_digits({18'd0, 3'b010, 3'b010}, 8, 0);
    idle_cycle();
    n_vec++; if (out_data !== 18'd5) begin n_err++; $display("FAIL bp_a_data: got %0d want 5", $signed(out_data)); end
    send_digits({18'd0, 3'b011, 3'b110}, 8, 0);
    idle_cycle();
    n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL bp_overrun: got %b want 1", overrun); end
    n_vec++; if (out_data !== 18'd5) begin n_err++; $display("FAIL bp_hold_data: got %0d want 5", $signed(out_data)); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid: got %b want 1", out_valid); end
    idle_cycle();
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL bp_overrun_len: got %b want 0", overrun); end
    out_ready = 1'b1;
    idle_cycle();
    out_ready = 1'b0;
    // Consume coincides with completion: new word replaces old
    send_digits({18'd0, 3'b010, 3'b010}, 8, 0);
    idle_cycle();
    send_digits({18'd0, 3'b011, 3'b110}, 8, 0);
    out_ready = 1'b1;
    idle_cycle();
    n_vec++; if (out_data !== 18'd7) begin n_err++; $display("FAIL bp_swap_data: got %0d want 7", $signed(out_data)); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_swap_valid: got %b want 1", out_valid); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL bp_swap_overrun: got %b want 0", overrun); end
    idle_cycle();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_swap_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_abort();
    int b_ab, b_v;
    out_ready = 1'b1;
    b_ab = abort_cnt;
    b_v  = valid_cnt;
    send_digits({8{3'b010}}, 4, 0);
    // -1 + 4 = 3
    send_digits({18'd0, 3'b010, 3'b110}, 8, 0);
    idle_cycle();
    n_vec++; if (out_data !== 18'd3) begin n_err++; $display("FAIL abort_data: got %0d want 3", $signed(out_data)); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL abort_valid: got %b want 1", out_valid); end
    idle_cycle();
    idle_cycle();
    n_vec++; if (abort_cnt - b_ab !== 1) begin n_err++; $display("FAIL abort_pulses: got %0d want 1", abort_cnt - b_ab); end
    n_vec++; if (valid_cnt - b_v !== 1) begin n_err++; $display("FAIL abort_words: got %0d want 1", valid_cnt - b_v); end
  endtask

  task automatic test_reset_mid();
    int b_ab, b_ov;
    out_ready = 1'b1;
    send_digits({8{3'b011}}, 5, 0);
    @(negedge clk);
    in_en = 1'b0; in_sof = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    b_ab = abort_cnt;
    b_ov = overrun_cnt;
    send_digits({21'd0, 3'b010}, 8, 0);
    idle_cycle();
    n_vec++; if (out_data !== 18'd1) begin n_err++; $display("FAIL rstmid_data: got %0d want 1", $signed(out_data)); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_valid: got %b want 1", out_valid); end
    idle_cycle();
    idle_cycle();
    n_vec++; if (abort_cnt - b_ab !== 0) begin n_err++; $display("FAIL rstmid_abort: got %0d want 0", abort_cnt - b_ab); end
    n_vec++; if (overrun_cnt - b_ov !== 0) begin n_err++; $display("FAIL rstmid_overrun: got %0d want 0", overrun_cnt - b_ov); end
  endtask

  task automatic test_back_to_back();
    int b_ab, b_v;
    out_ready = 1'b1;
    b_ab = abort_cnt;
    b_v  = valid_cnt;
    send_digits({18'd0, 3'b010, 3'b010}, 8, 0);
    send_digits({18'd0, 3'b010, 3'b110}, 8, 0);
    idle_cycle();
    n_vec++; if (out_data !== 18'd3) begin n_err++; $display("FAIL b2b_data: got %0d want 3", $signed(out_data)); end
    idle_cycle();
    idle_cycle();
    n_vec++; if (valid_cnt - b_v !== 2) begin n_err++; $display("FAIL b2b_words: got %0d want 2", valid_cnt - b_v); end
    n_vec++; if (abort_cnt - b_ab !== 0) begin n_err++; $display("FAIL b2b_abort: got %0d want 0", abort_cnt - b_ab); end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_extremes();
    test_gaps();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mrhy4_serial_to_parallel.md
Name: mrhy4_serial_to_parallel

Overview:
- Downstream stage of the butterfly unit. Consumes one digit-serial redundant radix-4 output stream (n2/p/pp digit lines, least-significant digit first, NDIG digits per frame).
- Converts each frame into a signed two's-complement parallel word for the output buffer / next FIR stage.
- Provides frame alignment, a one-entry output register with valid/ready handshake, and error strobes for overrun and aborted frames.

Parameters:
- NDIG, 8, digits per frame; matches the 3-bit frame counter of the butterfly path.
- OW, 18, output word width; must be >= 2*NDIG+2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_en  in  1  digit valid this cycle
- in_sof  in  1  marks digit 0 (LSD) of a frame; only meaningful with in_en=1
- in_n2  in  1  digit bit, weight -2
- in_p  in  1  digit bit, weight +1
- in_pp  in  1  digit bit, weight +1
- out_data  out  OW  signed converted word
- out_valid  out  1  out_data holds an unconsumed word
- out_ready  in  1  consumer accepts out_data when out_valid=1
- overrun  out  1  one-cycle pulse: completed frame dropped
- frame_abort  out  1  one-cycle pulse: partial frame discarded by new in_sof

Behaviour:
- Digit value d = in_p + in_pp - 2*in_n2, range -2..+2. All 8 codes are legal; {1,1,1} = 0.
- Frame value V = sum over k=0..NDIG-1 of d_k * 4^k, sign-extended to OW. For NDIG=8, range -43690..+43690.
- States: IDLE, COLLECT. Digit index k runs 0..NDIG-1. Accumulator acc is OW-bit signed.
- IDLE:
  - in_en && in_sof: acc <= d, k <= 1, go to COLLECT.
  - in_en without in_sof: digit ignored, no flag.
- COLLECT, in_en && !in_sof: acc <= acc + (d << 2k), k <= k+1.
- COLLECT, in_en && in_sof: frame_abort pulses next cycle; acc <= d, k <= 1, stay in COLLECT (restart).
- COLLECT, in_en=0: hold acc and k. Gaps are allowed.
- Completion: when digit k=NDIG-1 is accepted, the final sum is formed the same cycle and offered to the output register. The FSM returns to IDLE.
- Back-to-back frames: if in_sof arrives in the cycle immediately after completion, it is accepted as digit 0 of the next frame (IDLE handles it).
- Output register:
  - Loads the final sum at the clock edge that accepts the last digit, so out_valid=1 on the following cycle. Latency = 1 cycle from last digit to out_valid.
  - Handshake: a word is consumed on a cycle where out_valid && out_ready. out_valid then drops unless a new word loads on the same edge.
  - Completion while out_valid && !out_ready: the new word is dropped, out_data is held, and overrun pulses for 1 cycle.
  - Completion in the same cycle as a consume (out_valid && out_ready): the new word loads, out_valid stays 1, no overrun.
  - out_data is held stable while out_valid && !out_ready.
- Reset (any cycle, including mid-frame): state=IDLE, k=0, acc=0, out_data=0, out_valid=0, overrun=0, frame_abort=0. Any partial frame is discarded silently.
- Arithmetic: all sums are signed OW-bit, with no saturation. The OW >= 2*NDIG+2 bound guarantees no overflow.

Test Plan:
- All-ones: 8 digits {n2,p,pp}={0,1,0}, in_sof on the first, in_en continuous -> out_valid=1 exactly 1 cycle after the 8th digit; out_data=21845.
- Negative extreme: 8 digits {1,0,0} (d=-2), out_ready=1 -> out_data=-43690 (18'h3_5556). out_valid drops 1 cycle after the handshake. Then 8 digits {0,1,1} (d=+2) -> +43690.
- Mixed with gaps: d0=+2, d1=-1, d2..d7=0, with in_en deasserted for 3 cycles between digits -> out_data=-2. Redundant code {1,1,1} as d2 contributes 0.
- Backpressure: out_ready=0; frame A=5 completes, then frame B=7 completes -> overrun pulses 1 cycle at B's completion; out_data stays 5. Raising out_ready in the same cycle B completes instead gives out_data=7 with no overrun.
- Abort: 4 digits of a frame, then in_sof with a new 8-digit frame of value 3 -> frame_abort pulses once; out_data=3; only one out_valid.
- Reset mid-frame: rst high after digit 5 for 1 cycle; following full frame of value 1 -> out_data=1. No stale contribution; overrun=0, frame_abort=0.
